bcd_updown_timer: RTL and testbench
===================================

Name: bcd_updown_timer

Overview:
Parametrised up/down BCD stopwatch/countdown timer with integrated multiplexed 7-segment scan and LED bar. Generalises the lab-4 stopwatch to N digits, configurable tick, prepare and blink periods, and adds a direction latch, a terminal `done` flag and an optional lap/split freeze. Sits between the debounce/one_pulse front end (`start`, `stop`, `lap` arrive as 1-cycle pulses) and the board display pins.

Parameters:
- DIGITS, 3: number of BCD count digits; display has DIGITS+1 positions (MS position = mode symbol). Range 1..7.
- TICK_DIV, 1000000: clk cycles per count tick (0.01 s at 100 MHz). Must be >= 2.
- PREP_TICKS, 100: ticks spent in PREP before RUN.
- SCAN_DIV, 100000: clk cycles per display position advance.
- BLINK_TICKS, 50: ticks per LED blink half-period in HOLD.
- LED_W, 10: LED bar width.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous reset, active-high.
- start, in, 1: start/advance pulse, 1 clk wide.
- stop, in, 1: stop pulse, 1 clk wide.
- dir, in, 1: 1 = count up, 0 = count down; sampled only in IDLE.
- DIGIT, out, DIGITS+1: active-low one-hot display position select.
- DISPLAY, out, 7: active-low segments {g,f,e,d,c,b,a}.
- led, out, LED_W: LED bar.
- count, out, 4*DIGITS: live BCD count, digit 0 at LSBs.
- state_o, out, 2: current state encoding.
- done, out, 1: high in HOLD when terminal value was reached.

Behaviour:
- Reset (async, rst=1): state IDLE, count = all 0, dir_q = 1, done = 0, tick/scan/blink counters = 0, DIGIT = all 1 except bit0 = 0, led = all 1.
- Tick: counter 0..TICK_DIV-1; tick = 1 for one clk when counter == TICK_DIV-1. Counter is cleared on every state change, so the first tick after any transition arrives exactly TICK_DIV clks later.
- States: IDLE=0, PREP=1, RUN=2, HOLD=3.
- IDLE: dir_q <= dir every clk; count preset to all 0 (dir_q=1) or all 9 (dir_q=0); led all on; done = 0. start -> PREP.
- PREP: led all off; count frozen. After PREP_TICKS ticks -> RUN. start/stop ignored.
- RUN: each tick does a BCD ±1 with ripple (up: 9->0 carries; down: 0->9 borrows).
  - Terminal value (all 9 up, all 0 down) reached on a tick: count holds the terminal value, next state HOLD, done <= 1.
  - stop -> HOLD with done = 0, count frozen at its value in that clk.
  - stop coincident with a tick: the tick's update is discarded; HOLD shows the pre-tick value.
  - start ignored in RUN.
  - led = one-hot of the MS count digit (bit k set for value k; all 0 if k >= LED_W).
  - dir input changes have no effect (dir_q is latched).
- HOLD: count frozen. led toggles all-on/all-off every BLINK_TICKS ticks, starting with all-on, for 3 full periods, then stays all-on. start -> IDLE (done <= 0). stop ignored.
- Display scan: position advances every SCAN_DIV clks, cycling 0..DIGITS, wrapping to 0.
  - Positions 0..DIGITS-1 show count digits in RUN/HOLD, "-" in IDLE, blank in PREP.
  - Position DIGITS shows the mode symbol: "P" in PREP, otherwise "U" (dir_q=1) or "d" (dir_q=0).
  - DIGIT and DISPLAY change in the same clk; there is no ghost cycle.
- Encodings: 0-9 standard; U = 1011100; d = 1100011; P = 0001100; "-" = 0111111; blank = 1111111.
- rst mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro BCD_TIMER_LAP_EN.
- Defined:
  - Adds input port `lap` (1 bit, pulse).
  - In RUN, lap captures count into lap_q and sets lap_hold; the digit display shows lap_q while `count` keeps running. A second lap clears lap_hold.
  - lap_hold clears on entry to HOLD, so HOLD shows the final count.
  - lap is ignored outside RUN.
  - lap coincident with stop: stop wins; no capture.
- Undefined: no lap port; the display always shows the live count.

Decomposition:
- Package bcd_timer_pkg holds:
  - state typedef/localparams (IDLE, PREP, RUN, HOLD);
  - segment constants SEG_U, SEG_D, SEG_P, SEG_DASH, SEG_BLANK;
  - function bcd_to_seg(4b) -> 7b.
- One sub-module, seven_seg_scan:
  - parameters POSITIONS and SCAN_DIV;
  - inputs: flat 4b-per-position code bus plus per-position override segments;
  - outputs: DIGIT and DISPLAY.
- The BCD ripple and FSM stay in the top.

Test Plan:
Bench parameters: DIGITS=3, TICK_DIV=4, PREP_TICKS=2, SCAN_DIV=2, BLINK_TICKS=1.
- Reset then dir=1, start: state 0->1. RUN is entered 8 clks after PREP entry. count goes 000, 001 ... with 4 clks per step; led = 0000000001 while MS digit = 0.
- dir=0, start, run to completion: count goes 999, 998 ... 000. HOLD is entered at 000 with done=1. led then blinks on/off for 3 periods (6 ticks) and stays all-on. start -> IDLE, count = 999, done = 0.
- Up count, stop pulse exactly on the tick clk at count 009: HOLD with count = 009 (not 010) and done = 0. dir toggled during RUN leaves the direction unchanged.
- Ripple boundary: up from 099 -> 100; down from 100 -> 099; led moves from bit0 to bit1 on 099 -> 100.
- Scan check in IDLE with dir=0: DIGIT sequence 1110, 1101, 1011, 0111 with 2 clks each. DISPLAY shows "-" three times then "d". Assert rst mid-scan: DIGIT = 1110 and led = all 1 in the same cycle.
- With BCD_TIMER_LAP_EN: lap at count 005 -> display digits hold 005 while count reaches 008. A second lap -> display shows live 008. stop coincident with lap -> no capture; HOLD shows the live count.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared state encoding, segment constants and BCD-to-segment decode for bcd_updown_timer.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [6:0] SEG_U     = 7'b1011100;
  localparam logic [6:0] SEG_D     = 7'b1100011;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    case (code)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_scan.sv
// Multiplexed 7-segment scanner: one position active every SCAN_DIV clks, cycling 0..POSITIONS-1.
// DIGIT and DISPLAY both decode from the same position register, so they switch together.
module seven_seg_scan
  import bcd_timer_pkg::*;
#(
  parameter int POSITIONS = 4,
  parameter int SCAN_DIV  = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*POSITIONS-1:0] codes,
  input  logic [POSITIONS-1:0]   ovr_en,
  input  logic [7*POSITIONS-1:0] ovr_seg,
  output logic [POSITIONS-1:0]   DIGIT,
  output logic [6:0]             DISPLAY
);

  localparam int PW = $clog2(POSITIONS);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] scan_cnt;
  logic [PW-1:0] pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      pos      <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      pos      <= (pos == PW'(POSITIONS - 1)) ? '0 : pos + PW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  always_comb begin
    DIGIT      = '1;
    DIGIT[pos] = 1'b0;
    if (ovr_en[pos]) DISPLAY = ovr_seg[7*pos +: 7];
    else             DISPLAY = bcd_to_seg(codes[4*pos +: 4]);
  end

endmodule

// File: rtl/bcd_updown_timer.sv
// Up/down BCD stopwatch/countdown with prepare phase, terminal hold, LED bar and display scan.
// Define BCD_TIMER_LAP_EN to add the `lap` input (lap/split display freeze during RUN).
module bcd_updown_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS      = 3,
  parameter int TICK_DIV    = 1000000,
  parameter int PREP_TICKS  = 100,
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_TICKS = 50,
  parameter int LED_W       = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
`ifdef BCD_TIMER_LAP_EN
  input  logic                  lap,
`endif
  input  logic                  dir,
  output logic [DIGITS:0]       DIGIT,
  output logic [6:0]            DISPLAY,
  output logic [LED_W-1:0]      led,
  output logic [4*DIGITS-1:0]   count,
  output logic [1:0]            state_o,
  output logic                  done
);

  localparam int CW  = 4 * DIGITS;
  localparam int TW  = $clog2(TICK_DIV);
  localparam int PTW = $clog2(PREP_TICKS + 1);
  localparam int BTW = $clog2(BLINK_TICKS + 1);
  localparam logic [CW-1:0] ALL_NINES = {DIGITS{4'h9}};

  function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] v, input logic up);
    logic [CW-1:0] r;
    logic          carry;
    logic [3:0]    d;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (d == 4'd9) r[4*i +: 4] = 4'd0;
          else begin r[4*i +: 4] = d + 4'd1; carry = 1'b0; end
        end else begin
          if (d == 4'd0) r[4*i +: 4] = 4'd9;
          else begin r[4*i +: 4] = d - 4'd1; carry = 1'b0; end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [LED_W-1:0] led_onehot(input logic [3:0] d);
    logic [LED_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < LED_W; k++)
      if (32'(d) == k) r[k] = 1'b1;
    return r;
  endfunction

  state_t           state;
  logic             dir_q;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [PTW-1:0]   prep_cnt;
  logic [BTW-1:0]   blink_cnt;
  logic [2:0]       blink_ph;
  logic [CW-1:0]    next_cnt;
  logic             terminal;
  logic [CW-1:0]    shown;

  assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
  assign next_cnt = bcd_step(count, dir_q);
  assign terminal = dir_q ? (next_cnt == ALL_NINES) : (next_cnt == '0);
  assign state_o  = state;

  // Every transition branch clears tick_cnt, overriding the free-running default.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      dir_q     <= 1'b1;
      done      <= 1'b0;
      tick_cnt  <= '0;
      prep_cnt  <= '0;
      blink_cnt <= '0;
      blink_ph  <= '0;
      led       <= '1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      case (state)
        IDLE: begin
          dir_q <= dir;
          count <= dir_q ? '0 : ALL_NINES;
          led   <= '1;
          done  <= 1'b0;
          if (start) begin
            state    <= PREP;
            tick_cnt <= '0;
            prep_cnt <= '0;
            led      <= '0;
          end
        end
        PREP: begin
          led <= '0;
          if (tick) begin
            if (prep_cnt == PTW'(PREP_TICKS - 1)) begin
              state    <= RUN;
              tick_cnt <= '0;
              led      <= led_onehot(count[CW-1 -: 4]);
            end else begin
              prep_cnt <= prep_cnt + PTW'(1);
            end
          end
        end
        RUN: begin
          if (stop) begin
            state     <= HOLD;
            tick_cnt  <= '0;
            blink_cnt <= '0;
            blink_ph  <= '0;
            led       <= '1;
            done      <= 1'b0;
          end else if (tick) begin
            count <= next_cnt;
            if (terminal) begin
              state     <= HOLD;
              tick_cnt  <= '0;
              blink_cnt <= '0;
              blink_ph  <= '0;
              led       <= '1;
              done      <= 1'b1;
            end else begin
              led <= led_onehot(next_cnt[CW-1 -: 4]);
            end
          end
        end
        HOLD: begin
          if (start) begin
            state    <= IDLE;
            tick_cnt <= '0;
            done     <= 1'b0;
            count    <= dir_q ? '0 : ALL_NINES;
            led      <= '1;
          end else if (tick && blink_ph != 3'd6) begin
            if (blink_cnt == BTW'(BLINK_TICKS - 1)) begin
              blink_cnt <= '0;
              blink_ph  <= blink_ph + 3'd1;
              led       <= ~led;
            end else begin
              blink_cnt <= blink_cnt + BTW'(1);
            end
          end
        end
      endcase
    end
  end

`ifdef BCD_TIMER_LAP_EN
  logic          lap_hold;
  logic [CW-1:0] lap_q;

  // Any exit from RUN goes to HOLD, so clearing on stop/terminal covers HOLD entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_hold <= 1'b0;
      lap_q    <= '0;
    end else if (state == RUN) begin
      if (stop || (tick && terminal)) begin
        lap_hold <= 1'b0;
      end else if (lap) begin
        if (lap_hold) lap_hold <= 1'b0;
        else begin
          lap_q    <= count;
          lap_hold <= 1'b1;
        end
      end
    end
  end

  assign shown = lap_hold ? lap_q : count;
`else
  assign shown = count;
`endif

  logic [4*(DIGITS+1)-1:0] codes;
  logic [DIGITS:0]         ovr_en;
  logic [7*(DIGITS+1)-1:0] ovr_seg;

  always_comb begin
    codes   = {4'h0, shown};
    ovr_en  = '0;
    ovr_seg = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (state == IDLE) begin
        ovr_en[i]        = 1'b1;
        ovr_seg[7*i +: 7] = SEG_DASH;
      end else if (state == PREP) begin
        ovr_en[i]        = 1'b1;
        ovr_seg[7*i +: 7] = SEG_BLANK;
      end
    end
    ovr_en[DIGITS]             = 1'b1;
    ovr_seg[7*DIGITS +: 7]     = (state == PREP) ? SEG_P : (dir_q ? SEG_U : SEG_D);
  end

  seven_seg_scan #(
    .POSITIONS(DIGITS + 1),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .codes  (codes),
    .ovr_en (ovr_en),
    .ovr_seg(ovr_seg),
    .DIGIT  (DIGIT),
    .DISPLAY(DISPLAY)
  );

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Self-checking bench for bcd_updown_timer (DIGITS=3, TICK_DIV=4, PREP_TICKS=2, SCAN_DIV=2, BLINK_TICKS=1).
// Lap checks are compiled in when BCD_TIMER_LAP_EN is defined.
module tb_bcd_updown_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        lap = 1'b0;
  logic        dir = 1'b1;
  logic [3:0]  DIGIT;
  logic [6:0]  DISPLAY;
  logic [9:0]  led;
  logic [11:0] count;
  logic [1:0]  state_o;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  localparam logic [6:0] S_U = 7'b1011100, S_D = 7'b1100011, S_P = 7'b0001100;
  localparam logic [6:0] S_DASH = 7'b0111111, S_BLANK = 7'b1111111;
  localparam int HOLD_AT = 8 + 4 * 999;

  bcd_updown_timer #(
    .DIGITS(3), .TICK_DIV(4), .PREP_TICKS(2), .SCAN_DIV(2), .BLINK_TICKS(1), .LED_W(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef BCD_TIMER_LAP_EN
    .lap(lap),
`endif
    .dir(dir), .DIGIT(DIGIT), .DISPLAY(DISPLAY), .led(led),
    .count(count), .state_o(state_o), .done(done)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; the scan position follows from this alone.
  always @(posedge clk or posedge rst)
    if (rst) edges <= 0;
    else     edges <= edges + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  function automatic int run_val(input bit up, input int t);
    if (up) return (t > 999) ? 999 : t;
    return (t > 999) ? 0 : 999 - t;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [9:0] led_of(input int v);
    logic [9:0] one;
    one = 10'd1;
    return one << (v / 100);
  endfunction

  function automatic logic [6:0] seg_digit(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return S_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] exp_sel();
    logic [3:0] one;
    one = 4'd1;
    return ~(one << ((edges / 2) % 4));
  endfunction

  function automatic logic [6:0] exp_disp(input int st, input int val, input bit up);
    int pos;
    pos = (edges / 2) % 4;
    if (pos == 3) return (st == 1) ? S_P : (up ? S_U : S_D);
    if (st == 0) return S_DASH;
    if (st == 1) return S_BLANK;
    return seg_digit((val / ((pos == 0) ? 1 : (pos == 1) ? 10 : 100)) % 10);
  endfunction

  task automatic test_reset();
    #12;
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    n_cmp++; if (count !== 12'h000) begin n_bad++; $display("FAIL reset_count: got %h expected 000", count); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (DIGIT !== 4'b1110) begin n_bad++; $display("FAIL reset_digit: got %b expected 1110", DIGIT); end
    n_cmp++; if (led !== 10'h3FF) begin n_bad++; $display("FAIL reset_led: got %b expected all ones", led); end
    n_cmp++; if (DISPLAY !== S_DASH) begin n_bad++; $display("FAIL reset_display: got %b expected %b", DISPLAY, S_DASH); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (count !== 12'h000) begin n_bad++; $display("FAIL idle_up_preset: got %h expected 000", count); end
  endtask

  task automatic test_updown_run();
    bit sc_up[8];
    int sc_stop[8];
    bit sc_tog[8];
    sc_up[0] = 1; sc_stop[0] = 48;          sc_tog[0] = 1;  // stop on the tick reaching 010
    sc_up[1] = 1; sc_stop[1] = 8 + 400 + 2; sc_tog[1] = 0;  // 099 -> 100
    sc_up[2] = 0; sc_stop[2] = 8 + 3600 + 2; sc_tog[2] = 0; // 100 -> 099
    sc_up[3] = 1; sc_stop[3] = 20;          sc_tog[3] = 0;
    for (int s = 4; s < 8; s++) begin
      sc_up[s]   = 1'($urandom_range(0, 1));
      sc_stop[s] = $urandom_range(9, 170);
      sc_tog[s]  = 1;
    end
    for (int s = 0; s < 8; s++) begin
      bit up;
      int sa;
      up = sc_up[s];
      sa = sc_stop[s];
      dir = up;
      repeat (3) @(negedge clk);
      n_cmp++; if (count !== to_bcd(run_val(up, 0))) begin n_bad++; $display("FAIL idle_preset s=%0d: got %h expected %h", s, count, to_bcd(run_val(up, 0))); end
      start = 1'b1;
      for (int n = 0; n <= sa; n++) begin
        int st, val;
        logic [9:0] el;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        if (sc_tog[s] && n >= 8) dir = 1'($urandom_range(0, 1));
        if (n == sa) begin
          st = 3; val = run_val(up, (sa - 9) / 4); el = 10'h3FF;
        end else if (n < 8) begin
          st = 1; val = run_val(up, 0); el = 10'h000;
        end else begin
          st = 2; val = run_val(up, (n - 8) / 4); el = led_of(val);
        end
        n_cmp++; if (state_o !== 2'(st)) begin n_bad++; $display("FAIL run_state s=%0d n=%0d: got %0d expected %0d", s, n, state_o, st); end
        n_cmp++; if (count !== to_bcd(val)) begin n_bad++; $display("FAIL run_count s=%0d n=%0d: got %h expected %h", s, n, count, to_bcd(val)); end
        n_cmp++; if (led !== el) begin n_bad++; $display("FAIL run_led s=%0d n=%0d: got %b expected %b", s, n, led, el); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL run_done s=%0d n=%0d: got %b expected 0", s, n, done); end
        n_cmp++; if (DIGIT !== exp_sel()) begin n_bad++; $display("FAIL run_digit s=%0d n=%0d: got %b expected %b", s, n, DIGIT, exp_sel()); end
        n_cmp++; if (DISPLAY !== exp_disp(st, val, up)) begin n_bad++; $display("FAIL run_display s=%0d n=%0d: got %b expected %b", s, n, DISPLAY, exp_disp(st, val, up)); end
        if (n == sa - 1) stop = 1'b1;
      end
      dir = up;
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL back_idle s=%0d: got %0d expected 0", s, state_o); end
    end
  endtask

  task automatic test_countdown_done();
    dir = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    for (int n = 0; n <= HOLD_AT + 30; n++) begin
      int st, val, ph;
      logic [9:0] el;
      bit ed;
      @(negedge clk);
      start = 1'b0;
      ed = 1'b0;
      if (n < 8) begin
        st = 1; val = 999; el = 10'h000;
      end else if ((n - 8) / 4 < 999) begin
        st = 2; val = run_val(0, (n - 8) / 4); el = led_of(val);
      end else begin
        st = 3; val = 0; ed = 1'b1;
        ph = (n - HOLD_AT) / 4;
        if (ph > 6) ph = 6;
        el = (ph % 2 == 0) ? 10'h3FF : 10'h000;
      end
      n_cmp++; if (state_o !== 2'(st)) begin n_bad++; $display("FAIL down_state n=%0d: got %0d expected %0d", n, state_o, st); end
      n_cmp++; if (count !== to_bcd(val)) begin n_bad++; $display("FAIL down_count n=%0d: got %h expected %h", n, count, to_bcd(val)); end
      n_cmp++; if (done !== ed) begin n_bad++; $display("FAIL down_done n=%0d: got %b expected %b", n, done, ed); end
      n_cmp++; if (led !== el) begin n_bad++; $display("FAIL down_led n=%0d: got %b expected %b", n, led, el); end
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL done_idle_state: got %0d expected 0", state_o); end
    n_cmp++; if (count !== 12'h999) begin n_bad++; $display("FAIL done_idle_count: got %h expected 999", count); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_idle_done: got %b expected 0", done); end
  endtask

  task automatic test_scan_and_async_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); dir = 1'b0; rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++; if (DIGIT !== exp_sel()) begin n_bad++; $display("FAIL scan_digit k=%0d: got %b expected %b", k, DIGIT, exp_sel()); end
      n_cmp++; if (DISPLAY !== exp_disp(0, 0, 0)) begin n_bad++; $display("FAIL scan_display k=%0d: got %b expected %b", k, DISPLAY, exp_disp(0, 0, 0)); end
    end
    dir = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    n_cmp++; if (led !== 10'b0000000001) begin n_bad++; $display("FAIL pre_reset_led: got %b expected 0000000001", led); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (DIGIT !== 4'b1110) begin n_bad++; $display("FAIL async_digit: got %b expected 1110", DIGIT); end
    n_cmp++; if (led !== 10'h3FF) begin n_bad++; $display("FAIL async_led: got %b expected all ones", led); end
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL async_state: got %0d expected 0", state_o); end
    n_cmp++; if (count !== 12'h000) begin n_bad++; $display("FAIL async_count: got %h expected 000", count); end
    @(negedge clk); rst = 1'b0;
  endtask

`ifdef BCD_TIMER_LAP_EN
  task automatic test_lap();
    dir = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    for (int n = 0; n <= 52; n++) begin
      int st, val, dval;
      @(negedge clk);
      start = 1'b0; stop = 1'b0; lap = 1'b0;
      if (n == 52)    begin st = 3; val = run_val(1, (52 - 9) / 4); end
      else if (n < 8) begin st = 1; val = 0; end
      else            begin st = 2; val = run_val(1, (n - 8) / 4); end
      dval = (n >= 30 && n < 42) ? 5 : val;
      n_cmp++; if (state_o !== 2'(st)) begin n_bad++; $display("FAIL lap_state n=%0d: got %0d expected %0d", n, state_o, st); end
      n_cmp++; if (count !== to_bcd(val)) begin n_bad++; $display("FAIL lap_count n=%0d: got %h expected %h", n, count, to_bcd(val)); end
      n_cmp++; if (DISPLAY !== exp_disp(st, dval, 1)) begin n_bad++; $display("FAIL lap_display n=%0d: got %b expected %b", n, DISPLAY, exp_disp(st, dval, 1)); end
      if (n == 29 || n == 41) lap = 1'b1;
      if (n == 51) begin lap = 1'b1; stop = 1'b1; end
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_updown_run();
    test_countdown_done();
    test_scan_and_async_reset();
`ifdef BCD_TIMER_LAP_EN
    test_lap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
